// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the LEGv8 datapath: word and register-index
//   widths, the XZR index, ALU opcode encodings and a population-count
//   helper used by the register-file scoreboard.
//
//   Contents:
//     DATA_W      - datapath width (64)
//     NREGS       - number of architectural integer registers (32)
//     REG_IDX_W   - register index width (5)
//     PEND_CNT_W  - width of the pending-register count (6, holds 0..32)
//     ZERO_REG    - index of XZR (31)
//     word_t      - one datapath word
//     reg_idx_t   - one register index
//     cnt_t       - pending count
//     alu_op_t    - ALU operation encodings
//     popcount()  - number of set bits in a register-wide mask
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W     = 64;
  localparam int NREGS      = 32;
  localparam int REG_IDX_W  = $clog2(NREGS);
  localparam int PEND_CNT_W = REG_IDX_W + 1;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_IDX_W-1:0]  reg_idx_t;
  typedef logic [PEND_CNT_W-1:0] cnt_t;
  typedef logic [NREGS-1:0]      reg_mask_t;

  // XZR: reads as zero, writes are discarded.
  localparam reg_idx_t ZERO_REG = reg_idx_t'(31);

  // ALU control encodings used by the execute stage.
  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_ORR   = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } alu_op_t;

  // Number of set bits in a register mask.
  function automatic cnt_t popcount(input reg_mask_t mask);
    cnt_t cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + cnt_t'(mask[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Pending-write tracker for the register file. A register is marked
//   pending when a long-latency load targeting it is issued (pend_set) and
//   is released when its write-back arrives (reg_wr to the same index).
//   Reads of a pending register raise a stall unless the write-back is
//   happening in the very same cycle.
//
//   Ports:
//     clk       in   rising-edge clock
//     reset_n   in   asynchronous active-low reset
//     ra, rb    in   read-port indices to check for hazards
//     rw        in   write-back index
//     reg_wr    in   write-back enable
//     pend_set  in   mark pend_rd as awaiting a late write
//     pend_rd   in   index marked by pend_set
//     stall_a   out  ra is pending and not being written this cycle
//     stall_b   out  rb is pending and not being written this cycle
//     pend_cnt  out  number of pending registers (registered)
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_IDX_W-1:0]  ra,
  input  logic [REG_IDX_W-1:0]  rb,
  input  logic [REG_IDX_W-1:0]  rw,
  input  logic                  reg_wr,
  input  logic                  pend_set,
  input  logic [REG_IDX_W-1:0]  pend_rd,
  output logic                  stall_a,
  output logic                  stall_b,
  output logic [PEND_CNT_W-1:0] pend_cnt
);

  reg_mask_t pend_reg;
  reg_mask_t pend_next;
  cnt_t      pend_cnt_reg;

  // Per-register next-state. A set and a clear on the same edge means a new
  // load was issued as the previous one retired, so the set takes priority.
  // XZR can never become pending.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
    if (reg_idx_t'(gi) == ZERO_REG) begin : g_zero
      assign pend_next[gi] = 1'b0;
    end else begin : g_live
      logic set_hit;
      logic clr_hit;
      assign set_hit       = pend_set && (pend_rd == reg_idx_t'(gi));
      assign clr_hit       = reg_wr && (rw == reg_idx_t'(gi));
      assign pend_next[gi] = set_hit || (pend_reg[gi] && !clr_hit);
    end
  end

  // The count is registered from the same next-state vector as the pending
  // bits, so the two always describe the same set of registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_reg     <= '0;
      pend_cnt_reg <= '0;
    end else begin
      pend_reg     <= pend_next;
      pend_cnt_reg <= popcount(pend_next);
    end
  end

  // A write-back arriving this cycle resolves the hazard in time for the
  // consumer (forwarded or read next cycle), so it suppresses the stall.
  always_comb begin
    stall_a = pend_reg[ra] && !(reg_wr && (rw == ra));
    stall_b = pend_reg[rb] && !(reg_wr && (rw == rb));
  end

  assign pend_cnt = pend_cnt_reg;

endmodule

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   32 x 64-bit LEGv8 integer register file with two combinational read
//   ports, one synchronous write port and a pending-write scoreboard that
//   flags registers still waiting on late (multi-cycle) load data.
//   X31 (XZR) always reads as zero and ignores writes.
//
//   Build option:
//     REGFILE_BYPASS_EN  defined   -> a write in progress is forwarded to a
//                                     read port addressing the same register
//                                     in the same cycle.
//                        undefined -> reads return the pre-write contents
//                                     during the writing cycle.
//
//   Ports:
//     Clk      in   1   rising-edge clock
//     Reset_n  in   1   asynchronous active-low reset
//     RA, RB   in   5   read-port indices
//     BusA     out  64  read data A (combinational)
//     BusB     out  64  read data B (combinational)
//     RW       in   5   write index
//     RegWr    in   1   write enable
//     BusW     in   64  write data
//     PendSet  in   1   mark PendRd as awaiting a late write
//     PendRd   in   5   index for PendSet
//     StallA   out  1   RA pending and not written this cycle
//     StallB   out  1   RB pending and not written this cycle
//     PendCnt  out  6   number of pending registers
// ---------------------------------------------------------------------------
module register_file
  import cpu_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [REG_IDX_W-1:0]  RA,
  input  logic [REG_IDX_W-1:0]  RB,
  output logic [DATA_W-1:0]     BusA,
  output logic [DATA_W-1:0]     BusB,
  input  logic [REG_IDX_W-1:0]  RW,
  input  logic                  RegWr,
  input  logic [DATA_W-1:0]     BusW,
  input  logic                  PendSet,
  input  logic [REG_IDX_W-1:0]  PendRd,
  output logic                  StallA,
  output logic                  StallB,
  output logic [PEND_CNT_W-1:0] PendCnt
);

  word_t regs_reg [NREGS];
  logic  wr_en;
  logic  fwd_a;
  logic  fwd_b;

  // Writes aimed at XZR are dropped here, so XZR storage never changes.
  assign wr_en = RegWr && (RW != ZERO_REG);

  // Storage has an asynchronous clear, so it is built from flops rather
  // than a memory macro.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_en) begin
      regs_reg[RW] <= BusW;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Write-through: wr_en already excludes XZR, so XZR reads stay zero.
  assign fwd_a = wr_en && (RW == RA);
  assign fwd_b = wr_en && (RW == RB);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  always_comb begin
    BusA = regs_reg[RA];
    BusB = regs_reg[RB];
    if (fwd_a) begin
      BusA = BusW;
    end
    if (fwd_b) begin
      BusB = BusW;
    end
    if (RA == ZERO_REG) begin
      BusA = '0;
    end
    if (RB == ZERO_REG) begin
      BusB = '0;
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk      (Clk),
    .reset_n  (Reset_n),
    .ra       (RA),
    .rb       (RB),
    .rw       (RW),
    .reg_wr   (RegWr),
    .pend_set (PendSet),
    .pend_rd  (PendRd),
    .stall_a  (StallA),
    .stall_b  (StallB),
    .pend_cnt (PendCnt)
  );

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//   Self-checking bench for register_file: directed vector table, reset
//   and mid-operation reset sequences, then randomized traffic compared
//   against an array-based reference model.
// ---------------------------------------------------------------------------
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [63:0] D = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] F = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        Clk;
  logic        Reset_n;
  logic [4:0]  RA, RB, RW, PendRd;
  logic [63:0] BusA, BusB, BusW;
  logic        RegWr, PendSet;
  logic        StallA, StallB;
  logic [5:0]  PendCnt;

  register_file dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .RA      (RA),
    .RB      (RB),
    .BusA    (BusA),
    .BusB    (BusB),
    .RW      (RW),
    .RegWr   (RegWr),
    .BusW    (BusW),
    .PendSet (PendSet),
    .PendRd  (PendRd),
    .StallA  (StallA),
    .StallB  (StallB),
    .PendCnt (PendCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int passed = 0;
  int total  = 0;

  // Reference model: architectural state only.
  logic [63:0] m_regs [32];
  bit          m_pend [32];

  typedef struct {
    logic [4:0]  ra, rb, rw;
    logic        regwr;
    logic [63:0] busw;
    logic        pendset;
    logic [4:0]  pendrd;
    logic [63:0] exp_a, exp_b;
    logic        exp_sa, exp_sb;
    logic [5:0]  exp_cnt;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input int ra, input int rb, input int rw, input bit regwr,
                              input logic [63:0] busw, input bit pendset, input int pendrd,
                              input logic [63:0] ea, input logic [63:0] eb,
                              input bit sa, input bit sb, input int cnt);
    vec_t v;
    v.ra = 5'(ra); v.rb = 5'(rb); v.rw = 5'(rw); v.regwr = regwr; v.busw = busw;
    v.pendset = pendset; v.pendrd = 5'(pendrd);
    v.exp_a = ea; v.exp_b = eb; v.exp_sa = sa; v.exp_sb = sb; v.exp_cnt = 6'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                       input logic regwr, input logic [63:0] busw,
                       input logic pendset, input logic [4:0] pendrd);
    RA = ra; RB = rb; RW = rw; RegWr = regwr; BusW = busw; PendSet = pendset; PendRd = pendrd;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic logic [63:0] m_read(input logic [4:0] idx);
    if (idx == 5'd31) return '0;
    if (BYP && RegWr && RW == idx) return BusW;
    return m_regs[idx];
  endfunction

  function automatic logic m_stall(input logic [4:0] idx);
    return m_pend[idx] && !(RegWr && RW == idx);
  endfunction

  function automatic logic [5:0] m_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return 6'(c);
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".BusA"},    BusA,    m_read(RA));
    chk({tag, ".BusB"},    BusB,    m_read(RB));
    chk({tag, ".StallA"},  64'(StallA),  64'(m_stall(RA)));
    chk({tag, ".StallB"},  64'(StallB),  64'(m_stall(RB)));
    chk({tag, ".PendCnt"}, 64'(PendCnt), 64'(m_cnt()));
  endtask

  // Advance one clock; the model applies the rules to the inputs present at the edge.
  task automatic tick();
    @(posedge Clk);
    if (RegWr && RW != 5'd31) begin
      m_regs[RW] = BusW;
      m_pend[RW] = 1'b0;
    end
    if (PendSet && PendRd != 5'd31) m_pend[PendRd] = 1'b1;
    #1;
  endtask

  initial begin
    model_reset();
    Reset_n = 1'b0;
    // Activity while reset is held must have no effect.
    drive(5'd3, 5'd5, 5'd5, 1'b1, F, 1'b1, 5'd3);
    repeat (3) @(posedge Clk);
    #1;
    chk("hold.PendCnt", 64'(PendCnt), 64'd0);
    chk("hold.StallA",  64'(StallA),  64'd0);
    chk("hold.BusB",    BusB,         64'd0);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b0, 5'd0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    // Every register reads zero after reset.
    for (int r = 0; r < 32; r++) begin
      RA = 5'(r); RB = 5'(31 - r);
      #1;
      chk($sformatf("rst.BusA[%0d]", r), BusA, 64'd0);
      chk($sformatf("rst.BusB[%0d]", 31 - r), BusB, 64'd0);
      chk($sformatf("rst.Stall[%0d]", r), 64'({StallA, StallB}), 64'd0);
      chk($sformatf("rst.PendCnt[%0d]", r), 64'(PendCnt), 64'd0);
    end
    $display("reset sweep: 32 registers read");
    @(posedge Clk); #1;

    // Directed vectors; expectations are for outputs observed before the edge.
    vecs[0]  = mk(0, 31,  0, 0, 64'd0,   0, 0,  64'd0,  64'd0, 0, 0, 0);
    vecs[1]  = mk(4,  6,  5, 1, D,       0, 0,  64'd0,  64'd0, 0, 0, 0);
    vecs[2]  = mk(5, 31, 31, 1, F,       0, 0,  D,      64'd0, 0, 0, 0);
    vecs[3]  = mk(5, 31,  0, 0, 64'd0,   1, 7,  D,      64'd0, 0, 0, 0);
    vecs[4]  = mk(7, 31,  0, 0, 64'd0,   0, 0,  64'd0,  64'd0, 1, 0, 1);
    vecs[5]  = mk(7,  6,  7, 1, 64'd42,  0, 0,  BYP ? 64'd42 : 64'd0, 64'd0, 0, 0, 1);
    vecs[6]  = mk(7,  5,  9, 1, 64'd99,  1, 9,  64'd42, D,     0, 0, 0);
    vecs[7]  = mk(9,  5,  0, 0, 64'd0,   0, 0,  64'd99, D,     1, 0, 1);
    vecs[8]  = mk(9,  3,  3, 1, 64'h55,  1, 31, 64'd99, BYP ? 64'h55 : 64'd0, 1, 0, 1);
    vecs[9]  = mk(31, 3,  0, 0, 64'd0,   1, 9,  64'd0,  64'h55, 0, 0, 1);
    vecs[10] = mk(9, 31, 31, 1, 64'd123, 0, 0,  64'd99, 64'd0, 1, 0, 1);
    vecs[11] = mk(9,  7,  0, 0, 64'd0,   0, 0,  64'd99, 64'd42, 1, 0, 1);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].ra, vecs[i].rb, vecs[i].rw, vecs[i].regwr, vecs[i].busw,
            vecs[i].pendset, vecs[i].pendrd);
      #2;
      chk($sformatf("vec%0d.BusA", i),    BusA,         vecs[i].exp_a);
      chk($sformatf("vec%0d.BusB", i),    BusB,         vecs[i].exp_b);
      chk($sformatf("vec%0d.StallA", i),  64'(StallA),  64'(vecs[i].exp_sa));
      chk($sformatf("vec%0d.StallB", i),  64'(StallB),  64'(vecs[i].exp_sb));
      chk($sformatf("vec%0d.PendCnt", i), 64'(PendCnt), 64'(vecs[i].exp_cnt));
      $display("vec %0d: RA=%0d RB=%0d BusA=%h BusB=%h StallA=%b StallB=%b PendCnt=%0d",
               i, RA, RB, BusA, BusB, StallA, StallB, PendCnt);
      tick();
    end

    // Randomized traffic, indices concentrated on a few registers to force collisions.
    for (int c = 0; c < 400; c++) begin
      logic [4:0] ra_r, rb_r, rw_r, pr_r;
      ra_r = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rb_r = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rw_r = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      pr_r = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
      drive(ra_r, rb_r, rw_r, 1'($urandom_range(0, 1)), {$urandom, $urandom},
            1'($urandom_range(0, 2) == 0), pr_r);
      #2;
      check_model($sformatf("rnd%0d", c));
      $display("rnd %0d: RA=%0d RB=%0d RW=%0d RegWr=%b PendSet=%b PendRd=%0d PendCnt=%0d",
               c, RA, RB, RW, RegWr, PendSet, PendRd, PendCnt);
      tick();
    end

    // Mid-operation reset: in-flight write and pending bits are lost at once.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b1, 5'd12);
    tick();
    drive(5'd12, 5'd2, 5'd10, 1'b1, 64'd7, 1'b1, 5'd13);
    #1;
    chk("mid.StallA_before", 64'(StallA), 64'd1);
    Reset_n = 1'b0;
    #1;
    model_reset();
    chk("mid.PendCnt_async", 64'(PendCnt), 64'd0);
    chk("mid.StallA_async",  64'(StallA),  64'd0);
    chk("mid.BusB_async",    BusB,         64'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    drive(5'd10, 5'd13, 5'd0, 1'b0, 64'd0, 1'b0, 5'd0);
    #1;
    chk("mid.BusA_lost_write", BusA,          64'd0);
    chk("mid.StallB_after",    64'(StallB),   64'd0);
    chk("mid.PendCnt_after",   64'(PendCnt),  64'd0);
    $display("mid reset: BusA=%h StallB=%b PendCnt=%0d", BusA, StallB, PendCnt);
    tick();
    check_model("post");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Bound the run in case the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
